// File: rtl/if_stage_unit.sv
// -----------------------------------------------------------------------------
// if_stage_unit
//   Instruction-fetch stage with its IF/ID pipeline register. Generates the
//   fetch PC, runs a req/ack handshake to a variable-latency instruction
//   memory, redirects on branch_taken and holds its outputs under freeze.
//   The decoder sees {valid, pc, instruction}; pc is fetch address + 4.
//
// Optional feature macro: IF_PERF_CNT_EN
//   defined   : perf_fetched / perf_stall are live 32-bit wrapping counters
//   undefined : both ports are tied to 32'h0 and no counter flops exist
//
// Ports
//   clk            in   1   clock, all flops on posedge
//   rst            in   1   synchronous active-high reset
//   freeze         in   1   hazard stall, hold IF/ID outputs
//   branch_taken   in   1   redirect request from EXE
//   branch_address in   32  redirect target
//   imem_req       out  1   memory request valid
//   imem_addr      out  32  request address (word aligned)
//   imem_ack       in   1   response valid (may come in first req cycle)
//   imem_rdata     in   32  instruction word, sampled when imem_ack=1
//   valid          out  1   IF/ID holds a real fetched instruction
//   pc             out  32  fetch address + 4 of the output instruction
//   instruction    out  32  instruction to decoder
//   fetch_stall    out  1   waiting on memory (S_REQ or S_DROP, no ack)
//   perf_fetched   out  32  delivered-instruction count
//   perf_stall     out  32  fetch_stall cycle count
// -----------------------------------------------------------------------------
module if_stage_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        fetch_stall,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic [31:0] req_addr_r, req_addr_s;
    logic [31:0] skid_pc_r, skid_pc_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic        valid_r, valid_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] instr_r, instr_s;
    logic        req_active_s;

    // A request is live in S_REQ and S_DROP; reset abandons it immediately.
    assign req_active_s = (state_r != S_HOLD) && !rst;
    assign imem_req     = req_active_s;
    assign imem_addr    = req_addr_r;
    assign fetch_stall  = req_active_s && !imem_ack;
    assign valid        = valid_r;
    assign pc           = pc_r;
    assign instruction  = instr_r;

    // Next-state, fetch PC, skid buffer and IF/ID register computation.
    always_comb begin
        state_s      = state_r;
        fetch_pc_s   = fetch_pc_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        valid_s      = valid_r;
        pc_s         = pc_r;
        instr_s      = instr_r;
        if (branch_taken) begin
            // Redirect beats freeze: squash output and skid, retarget fetch.
            fetch_pc_s   = branch_address;
            valid_s      = 1'b0;
            pc_s         = 32'h0000_0000;
            instr_s      = NOP_INSTR;
            skid_pc_s    = 32'h0000_0000;
            skid_instr_s = 32'h0000_0000;
            case (state_r)
                S_REQ:   state_s = imem_ack ? S_REQ : S_DROP;
                S_DROP:  state_s = imem_ack ? S_REQ : S_DROP;
                S_HOLD:  state_s = S_REQ;
                default: state_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_ack) begin
                        fetch_pc_s = fetch_pc_r + 32'd4;
                        if (freeze) begin
                            // Park the word so nothing is lost while decode is stalled.
                            skid_pc_s    = fetch_pc_r + 32'd4;
                            skid_instr_s = imem_rdata;
                            state_s      = S_HOLD;
                        end else begin
                            valid_s = 1'b1;
                            pc_s    = fetch_pc_r + 32'd4;
                            instr_s = imem_rdata;
                        end
                    end else if (!freeze) begin
                        valid_s = 1'b0;
                        pc_s    = 32'h0000_0000;
                        instr_s = NOP_INSTR;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        valid_s = 1'b1;
                        pc_s    = skid_pc_r;
                        instr_s = skid_instr_r;
                        state_s = S_REQ;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                S_DROP: begin
                    // Stale response after a redirect: swallow it.
                    valid_s = 1'b0;
                    pc_s    = 32'h0000_0000;
                    instr_s = NOP_INSTR;
                    state_s = imem_ack ? S_REQ : S_DROP;
                end
                default: begin
                    valid_s = 1'b0;
                    pc_s    = 32'h0000_0000;
                    instr_s = NOP_INSTR;
                    state_s = S_REQ;
                end
            endcase
        end
        // The abandoned address must stay on the bus until its ack arrives.
        req_addr_s = (state_s == S_DROP) ? req_addr_r : fetch_pc_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_REQ;
            fetch_pc_r   <= RESET_PC;
            req_addr_r   <= RESET_PC;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
            valid_r      <= 1'b0;
            pc_r         <= 32'h0000_0000;
            instr_r      <= NOP_INSTR;
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            req_addr_r   <= req_addr_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            valid_r      <= valid_s;
            pc_r         <= pc_s;
            instr_r      <= instr_s;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;
    logic        deliver_s;

    // A real instruction is loaded into IF/ID this cycle.
    assign deliver_s = !branch_taken && !freeze &&
                       (((state_r == S_REQ) && imem_ack) || (state_r == S_HOLD));

    // Performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            perf_fetched_r <= perf_fetched_r + {31'd0, deliver_s};
            perf_stall_r   <= perf_stall_r + {31'd0, fetch_stall};
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`else
    assign perf_fetched = 32'h0000_0000;
    assign perf_stall   = 32'h0000_0000;
`endif

endmodule
